lsu_bus_if: RTL
===============

Name: lsu_bus_if

Overview:
- Load/store unit between the MEM stage and a variable-latency data bus.
- The bus uses a req/gnt request phase and an rvalid response phase.
- Replaces the fixed single-cycle data-memory port: generates byte/half/word(/double) lane masks, shifts write data, and sign/zero-extends read data.
- Detects misalignment, stalls the pipeline until the access completes, aborts on timeout and counts stall cycles.

Parameters:
- DATA_WIDTH, 32, bus and register width; legal values 32 or 64.
- TIMEOUT_CYCLES, 64, cycles allowed in REQ+RSP before abort; 0 disables the timeout.
- STALL_CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  MEM stage holds a load/store; held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double (legal only when DATA_WIDTH=64).
- req_unsigned  in  1  zero-extend load result (LBU/LHU/LWU).
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- stall  out  1  freeze IF..MEM and insert a bubble into WB.
- rsp_valid  out  1  one-cycle pulse: access completed.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- misaligned  out  1  one-cycle pulse: access rejected.
- bus_err  out  1  one-cycle pulse: timeout abort.
- bus_req  out  1  request phase active.
- bus_we  out  1  request is a write.
- bus_addr  out  DATA_WIDTH  request address, aligned to DATA_WIDTH/8.
- bus_wdata  out  DATA_WIDTH  write data replicated/shifted onto its lanes.
- bus_mask  out  DATA_WIDTH/8  byte-lane enables.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_WIDTH  read data, full bus word.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset: on an arst_n=0 clock edge, state=IDLE and all registers clear. All outputs are 0 from that edge, including bus_req, stall and stall_cnt. Reset mid-access abandons the access; a late gnt/rvalid is ignored.
- Offset: off = req_addr[log2(DATA_WIDTH/8)-1:0].
- Misaligned when any of:
  - size=1 and off[0]!=0;
  - size=2 and off[1:0]!=0;
  - size=3 and off!=0;
  - size=3 with DATA_WIDTH=32.
- Misaligned response, in IDLE: combinational misaligned=1, stall=0, rsp_valid=0, no bus access, state stays IDLE.
- FSM states: IDLE, REQ, RSP.
- IDLE, accepting a request: req_valid & aligned causes:
  - latch addr, we, size, unsigned, off, mask and shifted wdata;
  - combinational stall=1;
  - next state REQ.
- REQ: bus_req=1 with latched fields.
  - bus_gnt & store -> rsp_valid=1, stall=0, next IDLE (store latency 2 cycles minimum).
  - bus_gnt & load -> next RSP.
  - otherwise stall=1.
- RSP:
  - bus_rvalid -> rsp_valid=1, stall=0, next IDLE (load latency 3 cycles minimum).
  - otherwise stall=1.
- rsp_rdata: bus_rdata >> (8*latched off), truncated to the access size, then sign- or zero-extended. It is combinational in the completion cycle and 0 otherwise.
- Response ordering: rvalid in IDLE/REQ is ignored; the bus guarantees rvalid at least one cycle after gnt.
- Byte masks:
  - byte: 1<<off;
  - half: 3<<off;
  - word: 0xF<<off;
  - double: all ones.
- Write data is replicated across the bus word so each lane carries its byte.
- Timeout: a counter clears on entering REQ and increments each cycle in REQ/RSP. When it equals TIMEOUT_CYCLES-1 without completion:
  - bus_err=1, stall=0, rsp_valid=0;
  - next IDLE; bus_req drops.
- Completion takes priority over timeout in the same cycle.
- Repeat requests: the pipeline advances on the completion edge, so the same request is never re-issued. Back-to-back requests re-enter REQ the cycle after IDLE.
- stall_cnt increments on every stall=1 cycle and saturates at all-ones.

Decomposition:
- lsu_pkg holds:
  - the size enum (LSU_B, LSU_H, LSU_W, LSU_D);
  - the state enum;
  - the lsu_req_t struct (we, size, unsigned, addr, wdata);
  - the mask/extension functions.
- Sub-module lsu_align: combinational mask, wdata replication and rdata extraction/extension, shared with a future cache.

Test Plan:
- LW at 0x100, gnt in cycle 1, rvalid in cycle 2 with rdata=0xDEADBEEF -> stall=1 in cycles 0-1, rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF, stall_cnt=2.
- LB at 0x103 with rdata=0x80xxxxxx; LBU same -> bus_mask=4'b1000, rsp_rdata=0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH at 0x202 with wdata=0x1234, gnt delayed 3 cycles -> bus_mask=4'b1100, bus_wdata=0x12341234, rsp_valid 4 cycles after issue, then IDLE.
- LW at 0x101 -> misaligned pulse, bus_req never asserts, stall=0; LD with DATA_WIDTH=32 -> misaligned.
- TIMEOUT_CYCLES=4, load with no gnt -> bus_err pulse in the 4th REQ cycle, stall drops, next request accepted.
- arst_n low during RSP, rvalid one cycle later -> no rsp_valid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// the request bundle and the lane-mask / load-extension functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2,
        LSU_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_e;

    // Fields sized for the widest legal bus; narrower buses use the low bits.
    typedef struct packed {
        logic       we;
        lsu_size_e  size;
        logic       is_unsigned;
        logic [63:0] addr;
        logic [63:0] wdata;
    } lsu_req_t;

    function automatic logic [7:0] lsu_mask(input lsu_size_e size, input logic [2:0] off);
        case (size)
            LSU_B:   return 8'h01 << off;
            LSU_H:   return 8'h03 << off;
            LSU_W:   return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] lsu_extend(input logic [63:0] data, input lsu_size_e size,
                                               input logic is_unsigned);
        logic signed [63:0] sx;
        logic        [63:0] zx;
        case (size)
            LSU_B: begin
                sx = 64'($signed(data[7:0]));
                zx = 64'(data[7:0]);
            end
            LSU_H: begin
                sx = 64'($signed(data[15:0]));
                zx = 64'(data[15:0]);
            end
            LSU_W: begin
                sx = 64'($signed(data[31:0]));
                zx = 64'(data[31:0]);
            end
            default: begin
                sx = $signed(data);
                zx = data;
            end
        endcase
        return is_unsigned ? zx : sx;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: write mask and data replication onto bus lanes, and
// load-data extraction with sign/zero extension from a full bus word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                               wr_size_unused_guard,
    input  lsu_size_e                          wr_size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]    wr_off,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic [DATA_WIDTH/8-1:0]            wr_mask,
    output logic [DATA_WIDTH-1:0]              wr_bus_data,
    input  lsu_size_e                          rd_size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]    rd_off,
    input  logic                               rd_unsigned,
    input  logic [DATA_WIDTH-1:0]              rd_bus_data,
    output logic [DATA_WIDTH-1:0]              rd_data
);

    localparam int MASK_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] rd_shifted;

    assign wr_mask = MASK_W'(lsu_mask(wr_size, 3'(wr_off)) & {8{~wr_size_unused_guard}});

    // Each lane carries the byte of the access that would land on it at any offset.
    always_comb begin
        wr_bus_data = '0;
        for (int i = 0; i < MASK_W; i++) begin
            case (wr_size)
                LSU_B:   wr_bus_data[8*i +: 8] = wr_data[7:0];
                LSU_H:   wr_bus_data[8*i +: 8] = wr_data[8*(i%2) +: 8];
                LSU_W:   wr_bus_data[8*i +: 8] = wr_data[8*(i%4) +: 8];
                default: wr_bus_data[8*i +: 8] = wr_data[8*i +: 8];
            endcase
        end
    end

    assign rd_shifted = rd_bus_data >> {rd_off, 3'b000};
    assign rd_data    = DATA_WIDTH'(lsu_extend(64'(rd_shifted), rd_size, rd_unsigned));

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the MEM stage to a req/gnt + rvalid data bus:
// alignment check, lane steering, pipeline stall, timeout abort, stall counter.
module lsu_bus_if
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [DATA_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     stall,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     misaligned,
    output logic                     bus_err,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [DATA_WIDTH-1:0]    bus_addr,
    output logic [DATA_WIDTH-1:0]    bus_wdata,
    output logic [DATA_WIDTH/8-1:0]  bus_mask,
    input  logic                     bus_gnt,
    input  logic                     bus_rvalid,
    input  logic [DATA_WIDTH-1:0]    bus_rdata,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    lsu_state_e              state, state_d;
    lsu_req_t                req_p1;
    logic [OFF_W-1:0]        off_p1;
    logic [MASK_W-1:0]       mask_p1;
    logic [TMO_W-1:0]        tmo_cnt;

    lsu_size_e               size_in;
    logic [OFF_W-1:0]        req_off;
    logic                    mis;
    logic                    accept;
    logic                    tmo_hit;
    logic                    in_req;
    logic [MASK_W-1:0]       req_mask;
    logic [DATA_WIDTH-1:0]   req_wdata_rep;
    logic [DATA_WIDTH-1:0]   rd_ext;

    assign size_in = lsu_size_e'(req_size);
    assign req_off = req_addr[OFF_W-1:0];

    always_comb begin
        case (size_in)
            LSU_H:   mis = req_off[0];
            LSU_W:   mis = (req_off[1:0] != 2'b00);
            LSU_D:   mis = (DATA_WIDTH == 32) || (req_off != '0);
            default: mis = 1'b0;
        endcase
    end

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .wr_size_unused_guard (1'b0),
        .wr_size              (size_in),
        .wr_off               (req_off),
        .wr_data              (req_wdata),
        .wr_mask              (req_mask),
        .wr_bus_data          (req_wdata_rep),
        .rd_size              (req_p1.size),
        .rd_off               (off_p1),
        .rd_unsigned          (req_p1.is_unsigned),
        .rd_bus_data          (bus_rdata),
        .rd_data              (rd_ext)
    );

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Outputs are held quiet while reset is asserted so nothing leaks out before the clearing edge.
    always_comb begin
        state_d    = state;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        accept     = 1'b0;
        if (arst_n) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && mis) begin
                        misaligned = 1'b1;
                    end else if (req_valid) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt && req_p1.we) begin
                        rsp_valid = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (tmo_hit) begin
                        bus_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                        if (bus_gnt) state_d = ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus_rvalid) begin
                        rsp_valid = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (tmo_hit) begin
                        bus_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage p1: request fields captured on acceptance and held for the bus phases.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            req_p1    <= '0;
            off_p1    <= '0;
            mask_p1   <= '0;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                req_p1  <= '{we: req_we, size: size_in, is_unsigned: req_unsigned,
                             addr: 64'({req_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}}),
                             wdata: 64'(req_wdata_rep)};
                off_p1  <= req_off;
                mask_p1 <= req_mask;
                tmo_cnt <= '0;
            end else if (state != ST_IDLE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign in_req    = (state == ST_REQ);
    assign bus_req   = in_req;
    assign bus_we    = in_req & req_p1.we;
    assign bus_addr  = in_req ? DATA_WIDTH'(req_p1.addr) : '0;
    assign bus_wdata = in_req ? DATA_WIDTH'(req_p1.wdata) : '0;
    assign bus_mask  = in_req ? mask_p1 : '0;
    assign rsp_rdata = (rsp_valid && !req_p1.we) ? rd_ext : '0;

endmodule
